// File: rtl/led_scan_bcd_if.sv
// Bus bundling the display driver's value/control inputs and its pin-level outputs.
// The hex_mode signal exists only when LED_SCAN_HEX_MODE_EN is defined.
interface led_scan_bcd_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
);
  logic [WIDTH-1:0]  num;
  logic [DIGITS-1:0] dp_in;
  logic              lz_blank;
  logic              blank;
`ifdef LED_SCAN_HEX_MODE_EN
  logic              hex_mode;
`endif
  logic [DIGITS-1:0] anodes;
  logic [7:0]        cathodes;
  logic              busy;
  logic              overflow;

`ifdef LED_SCAN_HEX_MODE_EN
  modport master (
    output num, dp_in, lz_blank, blank, hex_mode,
    input  anodes, cathodes, busy, overflow
  );
  modport slave (
    input  num, dp_in, lz_blank, blank, hex_mode,
    output anodes, cathodes, busy, overflow
  );
`else
  modport master (
    output num, dp_in, lz_blank, blank,
    input  anodes, cathodes, busy, overflow
  );
  modport slave (
    input  num, dp_in, lz_blank, blank,
    output anodes, cathodes, busy, overflow
  );
`endif
endinterface

// File: rtl/led_scan_bcd.sv
// Multiplexed common-anode 7-segment driver with a sequential double-dabble converter.
// Optional hex display mode is enabled by defining LED_SCAN_HEX_MODE_EN.
module led_scan_bcd #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  led_scan_bcd_if.slave bus
);

  // Converter holds enough BCD nibbles for the full input range, at least DIGITS.
  localparam int NB = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
  localparam int BW = 4 * NB;
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shift_reg, shift_next;
  logic [BW-1:0]     bcd_reg, bcd_next, bcd_adj;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              ovf_pend_reg, ovf_pend_next;
  logic [DW-1:0]     disp_reg, disp_next;
  logic              ovf_reg, ovf_next;
  logic [63:0]       num_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_pend_reg <= 1'b0;
      disp_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bcd_reg      <= bcd_next;
      cnt_reg      <= cnt_next;
      ovf_pend_reg <= ovf_pend_next;
      disp_reg     <= disp_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bcd_next      = bcd_reg;
    cnt_next      = cnt_reg;
    ovf_pend_next = ovf_pend_reg;
    disp_next     = disp_reg;
    ovf_next      = ovf_reg;
    num_wide      = 64'(bus.num);

    bcd_adj = bcd_reg;
    for (int k = 0; k < NB; k++) begin
      if (bcd_reg[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
    end

    case (state_reg)
      IDLE: begin
        shift_next    = bus.num;
        bcd_next      = '0;
        cnt_next      = '0;
        ovf_pend_next = (num_wide >= LIMIT);
        state_next    = SHIFT;
`ifdef LED_SCAN_HEX_MODE_EN
        // Hex values need no conversion: nibbles go straight to LOAD.
        if (bus.hex_mode) begin
          bcd_next      = BW'(num_wide[DW-1:0]);
          ovf_pend_next = |(num_wide >> DW);
          state_next    = LOAD;
        end
`endif
      end
      SHIFT: begin
        {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) state_next = LOAD;
      end
      LOAD: begin
        // Digits and overflow flag update together so the display never mixes values.
        disp_next  = bcd_reg[DW-1:0];
        ovf_next   = ovf_pend_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy     = (state_reg == SHIFT) || (state_reg == LOAD);
  assign bus.overflow = ovf_reg;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
`ifdef LED_SCAN_HEX_MODE_EN
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      4'hF:    decode = 7'b0111000;
`endif
      default: decode = 7'b1111111;
    endcase
  endfunction

  // A digit is leading-zero blanked when it and every digit to its left are zero.
  logic [DIGITS-1:0] lz_kill;
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_kill  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero && (disp_reg[4*k +: 4] == 4'd0);
      lz_kill[k] = bus.lz_blank && all_zero && (k != 0);
    end
  end

  logic [DIGITS-1:0][7:0] seg_all;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign seg_all[gi] = ovf_reg     ? 8'b1111_1101 :
                           lz_kill[gi] ? {7'b1111111, ~bus.dp_in[gi]} :
                                         {decode(disp_reg[4*gi +: 4]), ~bus.dp_in[gi]};
    end
  endgenerate

  logic [PW-1:0]     pcnt_reg;
  logic [IW-1:0]     idx_reg;
  logic [DIGITS-1:0] anodes_reg;
  logic [7:0]        cathodes_reg;

  // Anodes and cathodes share one register stage so a digit is never lit with stale segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg     <= '0;
      idx_reg      <= IW'(DIGITS - 1);
      anodes_reg   <= '0;
      cathodes_reg <= 8'hFF;
    end else begin
      if (pcnt_reg == PW'(PRESCALE - 1)) begin
        pcnt_reg <= '0;
        idx_reg  <= (idx_reg == '0) ? IW'(DIGITS - 1) : idx_reg - 1'b1;
      end else begin
        pcnt_reg <= pcnt_reg + 1'b1;
      end
      anodes_reg   <= bus.blank ? '0 : (DIGITS'(1) << idx_reg);
      cathodes_reg <= seg_all[idx_reg];
    end
  end

  assign bus.anodes   = anodes_reg;
  assign bus.cathodes = cathodes_reg;

endmodule

// File: tb/tb_led_scan_bcd.sv
// Self-checking bench for led_scan_bcd: vector table plus scoreboard of expected scan digits.
module tb_led_scan_bcd;
  localparam int DIGITS   = 4;
  localparam int WIDTH    = 16;
  localparam int PRESCALE = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_scan_bcd_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  led_scan_bcd #(.DIGITS(DIGITS), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] num;
    logic [3:0]       dp;
    logic             lz;
    logic [3:0][7:0]  cath;
    logic             ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] cath;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_digits(input logic [3:0][7:0] cath);
    exp_t e;
    for (int d = 3; d >= 0; d--) begin
      e.anode = 4'b0001 << d;
      e.cath  = cath[d];
      sb.push_back(e);
    end
  endtask

  task automatic wait_busy_fall(input string tag);
    bit seen;
    int n;
    seen = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.busy) seen = 1'b1;
      else if (seen) break;
    end
    if (n == 200) begin
      checks++;
      $display("FAIL %s: timeout waiting for conversion end", tag);
    end
  endtask

  task automatic observe(input string tag, input logic exp_ovf);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (bus.anodes !== 4'b1000 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) begin
      checks++;
      $display("FAIL %s scan_start: anodes %b never reached 1000", tag, bus.anodes);
      sb.delete();
      return;
    end
    check($sformatf("%s overflow", tag), 32'(bus.overflow), 32'(exp_ovf));
    for (int d = 0; d < 4; d++) begin
      e = sb.pop_front();
      check($sformatf("%s anodes[%0d]", tag, d), 32'(bus.anodes), 32'(e.anode));
      check($sformatf("%s cathodes[%0d]", tag, d), 32'(bus.cathodes), 32'(e.cath));
      if (d < 3) @(negedge clk);
    end
    $display("%s: num=%0d lz=%0b dp=%b overflow=%0b checked", tag, bus.num, bus.lz_blank, bus.dp_in, bus.overflow);
  endtask

  task automatic apply(input vec_t v, input string tag);
    bus.num      = v.num;
    bus.dp_in    = v.dp;
    bus.lz_blank = v.lz;
    push_digits(v.cath);
    wait_busy_fall(tag);
    wait_busy_fall(tag);
    observe(tag, v.ovf);
  endtask

  initial begin
    logic [3:0] a0;
    int         k0;
    int         ki;

    vecs[0] = '{num: 16'd9,     dp: 4'b0001, lz: 1'b0, cath: {8'h03, 8'h03, 8'h03, 8'h08}, ovf: 1'b0};
    vecs[1] = '{num: 16'd7,     dp: 4'b0010, lz: 1'b1, cath: {8'hFF, 8'hFF, 8'hFE, 8'h1F}, ovf: 1'b0};
    vecs[2] = '{num: 16'd0,     dp: 4'b0000, lz: 1'b1, cath: {8'hFF, 8'hFF, 8'hFF, 8'h03}, ovf: 1'b0};
    vecs[3] = '{num: 16'd10000, dp: 4'b1111, lz: 1'b0, cath: {8'hFD, 8'hFD, 8'hFD, 8'hFD}, ovf: 1'b1};
    vecs[4] = '{num: 16'd9999,  dp: 4'b0000, lz: 1'b0, cath: {8'h09, 8'h09, 8'h09, 8'h09}, ovf: 1'b0};
    vecs[5] = '{num: 16'd305,   dp: 4'b0100, lz: 1'b1, cath: {8'hFF, 8'h0C, 8'h03, 8'h49}, ovf: 1'b0};
    vecs[6] = '{num: 16'd65535, dp: 4'b0000, lz: 1'b1, cath: {8'hFD, 8'hFD, 8'hFD, 8'hFD}, ovf: 1'b1};
    vecs[7] = '{num: 16'd8080,  dp: 4'b1111, lz: 1'b0, cath: {8'h00, 8'h02, 8'h00, 8'h02}, ovf: 1'b0};
    vecs[8] = '{num: 16'd56,    dp: 4'b1000, lz: 1'b1, cath: {8'hFE, 8'hFF, 8'h49, 8'h41}, ovf: 1'b0};

    bus.num      = 16'd1234;
    bus.dp_in    = 4'b0000;
    bus.lz_blank = 1'b0;
    bus.blank    = 1'b0;
`ifdef LED_SCAN_HEX_MODE_EN
    bus.hex_mode = 1'b0;
`endif

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    check("reset anodes", 32'(bus.anodes), 32'h0);
    check("reset cathodes", 32'(bus.cathodes), 32'hFF);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset overflow", 32'(bus.overflow), 32'h0);
    $display("reset: anodes=%b cathodes=%h busy=%0b", bus.anodes, bus.cathodes, bus.busy);

    // First conversion latency after reset release (WIDTH+2 cycles).
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check("lat c1 busy", 32'(bus.busy), 32'h1);
        check("lat c1 anodes", 32'(bus.anodes), 32'h8);
        check("lat c1 cathodes", 32'(bus.cathodes), 32'h03);
      end
      if (cyc == 17) check("lat c17 busy", 32'(bus.busy), 32'h1);
      if (cyc == 18) begin
        check("lat c18 busy", 32'(bus.busy), 32'h0);
        check("lat c18 anodes", 32'(bus.anodes), 32'h4);
        check("lat c18 cathodes", 32'(bus.cathodes), 32'h03);
      end
      if (cyc == 19) begin
        check("lat c19 anodes", 32'(bus.anodes), 32'h2);
        check("lat c19 cathodes", 32'(bus.cathodes), 32'h0D);
      end
      if (cyc == 20) begin
        check("lat c20 anodes", 32'(bus.anodes), 32'h1);
        check("lat c20 cathodes", 32'(bus.cathodes), 32'h99);
      end
      if (cyc == 21) begin
        check("lat c21 anodes", 32'(bus.anodes), 32'h8);
        check("lat c21 cathodes", 32'(bus.cathodes), 32'h9F);
      end
    end
    $display("latency: 1234 visible after conversion");

    for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // num changes during SHIFT: old value completes, new value follows one conversion later.
    bus.num = 16'd1234; bus.dp_in = 4'b0000; bus.lz_blank = 1'b0;
    wait_busy_fall("mid prep");
    wait_busy_fall("mid prep");
    repeat (6) @(negedge clk);
    bus.num = 16'd4321;
    push_digits({8'h9F, 8'h25, 8'h0D, 8'h99});
    wait_busy_fall("mid old");
    observe("mid old", 1'b0);
    push_digits({8'h99, 8'h0D, 8'h25, 8'h9F});
    wait_busy_fall("mid new");
    observe("mid new", 1'b0);

    // Global blank: anodes off for 5 cycles, scan keeps advancing underneath.
    @(negedge clk);
    a0 = bus.anodes;
    check("blank pre onehot", 32'($onehot(a0)), 32'h1);
    k0 = 0;
    for (int b = 0; b < 4; b++) if (a0[b]) k0 = b;
    bus.blank = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("blank anodes c%0d", c), 32'(bus.anodes), 32'h0);
    end
    bus.blank = 1'b0;
    @(negedge clk);
    ki = ((k0 - 6) % 4 + 4) % 4;
    check("blank resume anodes", 32'(bus.anodes), 32'(4'b0001 << ki));
    $display("blank: resumed at digit %0d", ki);

`ifdef LED_SCAN_HEX_MODE_EN
    bus.hex_mode = 1'b1; bus.num = 16'hBEEF; bus.dp_in = 4'b0000; bus.lz_blank = 1'b0;
    push_digits({8'hC1, 8'h61, 8'h61, 8'h71});
    wait_busy_fall("hex");
    @(negedge clk);
    check("hex busy load", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("hex busy idle", 32'(bus.busy), 32'h0);
    observe("hex", 1'b0);
    bus.hex_mode = 1'b0;
`endif

    // Asynchronous reset in the middle of SHIFT.
    bus.num = 16'd10000; bus.lz_blank = 1'b0; bus.dp_in = 4'b0000;
    wait_busy_fall("rst prep");
    wait_busy_fall("rst prep");
    check("rst prep overflow", 32'(bus.overflow), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst anodes", 32'(bus.anodes), 32'h0);
    check("async rst cathodes", 32'(bus.cathodes), 32'hFF);
    check("async rst busy", 32'(bus.busy), 32'h0);
    check("async rst overflow", 32'(bus.overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst anodes", 32'(bus.anodes), 32'h8);
    check("post rst cathodes", 32'(bus.cathodes), 32'h03);
    check("post rst overflow", 32'(bus.overflow), 32'h0);
    $display("async reset: outputs cleared mid-conversion");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
